// File: rtl/differential_pkg.sv
// Shared definitions for the differential dibit encoder and any matching decoder:
// FSM states, preamble symbol and quadrant/Gray helper functions.
package differential_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_t;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b11;

  // Dibit to quadrant increment: 00->0, 01->1, 11->2, 10->3 (inverse Gray).
  function automatic logic [1:0] dibit_to_inc(input logic [1:0] dibit);
    return {dibit[1], dibit[1] ^ dibit[0]};
  endfunction

  function automatic logic [1:0] gray_encode(input logic [1:0] quad);
    return {quad[1], quad[1] ^ quad[0]};
  endfunction

  function automatic logic [1:0] next_quadrant(input logic [1:0] quad, input logic [1:0] dibit);
    return quad + dibit_to_inc(dibit);
  endfunction

endpackage

// File: rtl/differential_encoder_if.sv
// Frame control, input dibit stream and encoded output stream of the encoder.
interface differential_encoder_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             in_b2k;
  logic             in_b2k_plus1;
  logic             in_valid;
  logic             in_ready;
  logic             delta_k;
  logic             delta_k_plus1;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  modport master (
    output start, frame_len, in_b2k, in_b2k_plus1, in_valid, out_ready,
    input  in_ready, delta_k, delta_k_plus1, out_valid, out_last, busy
  );

  modport slave (
    input  start, frame_len, in_b2k, in_b2k_plus1, in_valid, out_ready,
    output in_ready, delta_k, delta_k_plus1, out_valid, out_last, busy
  );
endinterface

// File: rtl/differential_encoder.sv
// Differential QPSK dibit encoder: emits a fixed preamble of 11 dibits, then
// frame_len data dibits, each as the Gray code of the accumulated phase quadrant.
module differential_encoder
  import differential_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int LEN_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  differential_encoder_if.slave bus
);

  localparam int PRE_W = 8;

  state_t           state, state_nxt;
  logic [1:0]       q;
  logic [PRE_W-1:0] pre_cnt;
  logic [LEN_W-1:0] data_cnt;
  logic [LEN_W-1:0] len_q;
  logic             vld_p1;
  logic             last_p1;
  logic [1:0]       dibit_p1;

  logic             slot_free;
  logic             take_start;
  logic             load;
  logic             load_last;
  logic             in_ready_c;
  logic [1:0]       load_dibit;
  logic [1:0]       q_nxt;
  logic             last_pre;
  logic             last_data;

  assign slot_free = !vld_p1 || bus.out_ready;
  assign last_pre  = (pre_cnt == PRE_W'(PREAMBLE_LEN - 1));
  assign last_data = ((data_cnt + LEN_W'(1)) == len_q);
  assign q_nxt     = next_quadrant(q, load_dibit);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    load       = 1'b0;
    load_last  = 1'b0;
    in_ready_c = 1'b0;
    load_dibit = PREAMBLE_DIBIT;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          take_start = 1'b1;
          state_nxt  = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (slot_free) begin
          load = 1'b1;
          if (last_pre) begin
            // An empty frame terminates on the final preamble symbol.
            if (len_q == '0) begin
              load_last = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        in_ready_c = slot_free;
        load_dibit = {bus.in_b2k, bus.in_b2k_plus1};
        if (bus.in_valid && slot_free) begin
          load = 1'b1;
          if (last_data) begin
            load_last = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase accumulator, counters and output register (stage p1).
  always_ff @(posedge clk) begin
    if (!rst) begin
      q        <= 2'b00;
      pre_cnt  <= '0;
      data_cnt <= '0;
      len_q    <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      dibit_p1 <= 2'b00;
    end else begin
      if (take_start) begin
        q        <= 2'b00;
        pre_cnt  <= '0;
        data_cnt <= '0;
        len_q    <= bus.frame_len;
      end
      if (load) begin
        q        <= q_nxt;
        dibit_p1 <= gray_encode(q_nxt);
        last_p1  <= load_last;
        vld_p1   <= 1'b1;
        if (state == ST_PREAMBLE) pre_cnt  <= pre_cnt + PRE_W'(1);
        else                      data_cnt <= data_cnt + LEN_W'(1);
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.delta_k       = dibit_p1[1];
  assign bus.delta_k_plus1 = dibit_p1[0];
  assign bus.out_valid     = vld_p1;
  assign bus.out_last      = last_p1;
  assign bus.busy          = (state != ST_IDLE);

endmodule

// File: doc/differential_encoder.md
DIFFERENTIAL_ENCODER -- requirements
Module: differential_encoder

Interface
REQ-001 Parameter PREAMBLE_LEN, default 8: number of preamble symbols emitted per frame (range 1..255).
REQ-002 Parameter LEN_W, default 16: width of frame_len.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle frame request; honoured only in IDLE.
REQ-006 frame_len  input  LEN_W  data-symbol count for the frame; sampled when start is honoured.
REQ-007 in_b2k, in_b2k_plus1  input  1 each  data dibit {b2k, b2k+1}.
REQ-008 in_valid  input  1  data dibit present.
REQ-009 in_ready  output  1  encoder accepts the dibit this cycle.
REQ-010 delta_k, delta_k_plus1  output  1 each  encoded dibit {d2k, d2k+1}, Gray code of the absolute phase quadrant.
REQ-011 out_valid  output  1  encoded dibit present.
REQ-012 out_ready  input  1  downstream accepts the encoded dibit.
REQ-013 out_last  output  1  qualifies the final symbol of the frame.
REQ-014 busy  output  1  high when not in IDLE.

Function
REQ-015 Dibit-to-increment map SHALL be 00->0, 01->+1, 11->+2, 10->+3 quadrants; next quadrant q' = (q + inc) mod 4 (2-bit wrap).
REQ-016 Output dibit SHALL be Gray(q'): 0->00, 1->01, 2->11, 3->10.
REQ-017 FSM states SHALL be IDLE, PREAMBLE, DATA.
REQ-018 IDLE -> PREAMBLE on start: q cleared to 0, frame_len latched, preamble counter cleared.
REQ-019 PREAMBLE SHALL internally generate PREAMBLE_LEN symbols of dibit 11, encoded per REQ-015/016, one per output slot; in_ready SHALL remain 0.
REQ-020 PREAMBLE -> DATA after the last preamble symbol loads into the output register; q SHALL carry over unchanged.
REQ-021 Zero-length frame: if latched frame_len = 0, the final preamble symbol SHALL carry out_last=1, and the FSM SHALL go PREAMBLE -> IDLE.
REQ-022 In DATA, in_ready SHALL be (!out_valid || out_ready); a transfer occurs when in_valid && in_ready.
REQ-023 Each data transfer SHALL update q and load the output register; out_valid SHALL rise the following cycle (latency 1).
REQ-024 The output register SHALL hold delta and out_last stable while out_valid && !out_ready.
REQ-025 A data counter SHALL count transfers; the frame_len-th data symbol SHALL carry out_last=1, and the FSM SHALL go DATA -> IDLE on that transfer.
REQ-026 In IDLE, out_valid SHALL clear once the pending symbol is accepted; a new start SHALL be honoured only when not busy.
REQ-027 A start outside IDLE SHALL be ignored; frame_len changes mid-frame SHALL have no effect.
REQ-028 Back-to-back transfers SHALL sustain one symbol per cycle when out_ready is held high.

Reset
REQ-029 On rst=0 at a clock edge: state IDLE, q=0, counters 0, out_valid=0, delta_k=0, delta_k_plus1=0, out_last=0, busy=0, in_ready=0.
REQ-030 Reset mid-frame SHALL abort the frame with no further output; the next frame SHALL start from q=0.

Structure
REQ-031 A shared package differential_pkg SHALL hold the FSM state enum, the PREAMBLE_DIBIT constant (2'b11), and the Gray encode/increment functions, for reuse by decoder-side logic.
REQ-032 No sub-module SHALL be used; the FSM, phase accumulator and output register are coded in one module.

Verification
REQ-033 Scenario: reset, then start with frame_len=4 and out_ready=1 -> preamble outputs 11,00,11,00,11,00,11,00; data 00,01,11,10 -> outputs 00,01,10,11; out_last on 11; busy low afterwards.
REQ-034 Scenario: out_ready held 0 for 3 cycles mid-data -> delta and out_last stable, in_ready=0, no symbol lost or duplicated.
REQ-035 Scenario: frame_len=0 -> exactly 8 preamble symbols, out_last on the 8th, in_ready never high.
REQ-036 Scenario: data dibits 01 x5 -> q wraps 1,2,3,0,1 -> outputs 01,11,10,00,01.
REQ-037 Scenario: rst=0 asserted during the 2nd data symbol -> all outputs 0 the next cycle; a following frame repeats the REQ-033 output sequence exactly.
REQ-038 Scenario: start pulsed again during DATA with a different frame_len -> ignored; the original frame completes with the original length.
